shim_fanout: RTL

SHIM_FANOUT -- requirements
Module: shim_fanout

---
 rtl/shim_pkg.sv | 13 +
 rtl/shim_lane_pending.sv | 37 +++
 rtl/shim_fanout.sv | 93 +++++++++
 3 files changed

// File: rtl/shim_pkg.sv
// Definitions shared by the shim blocks (fan-out and aligner): the state encoding
// of the two-state handshake controller.
package shim_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } shim_state_e;

endpackage : shim_pkg

// File: rtl/shim_lane_pending.sv
// One downstream lane: holds its pending flag and detects its valid/ready handshake.
module shim_lane_pending (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic mask_bit_i,
    input  logic send_i,
    input  logic ready_i,
    output logic valid_o,
    output logic handshake_o
);

    logic pending_q;
    logic pending_d;

    // A lane is offered only while the controller is sending.
    assign valid_o     = pending_q & send_i;
    assign handshake_o = valid_o & ready_i;

    always_comb begin
        pending_d = pending_q;
        if (load_i) begin
            pending_d = mask_bit_i;
        end else if (handshake_o) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule : shim_lane_pending

// File: rtl/shim_fanout.sv
// Captures one bundle of signed lane values and offers it to each selected downstream
// lane independently, pulsing DONE_OUT once every selected lane has taken it.
module shim_fanout
    import shim_pkg::*;
#(
    parameter int NUM_OUTPUTS = 1,
    parameter int WIDTH       = 8
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_IN,
    input  logic                                VALID_IN,
    input  logic        [NUM_OUTPUTS-1:0]       LANE_MASK_IN,
    output logic                                READY_OUT,
    output logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
    output logic        [NUM_OUTPUTS-1:0]       VALIDS_OUT,
    input  logic        [NUM_OUTPUTS-1:0]       READYS_IN,
    output logic                                DONE_OUT
);

    shim_state_e state_q;
    shim_state_e state_d;
    logic        done_q;
    logic        done_d;
    logic        load;
    logic        send;
    logic signed [NUM_OUTPUTS*WIDTH-1:0] values_q;
    logic        [NUM_OUTPUTS-1:0]       valids;
    logic        [NUM_OUTPUTS-1:0]       handshakes;

    assign send = (state_q == SEND);

    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_lane
            shim_lane_pending u_lane (
                .clk_i       (CLK),
                .rst_ni      (RSTN),
                .load_i      (load),
                .mask_bit_i  (LANE_MASK_IN[gi]),
                .send_i      (send),
                .ready_i     (READYS_IN[gi]),
                .valid_o     (valids[gi]),
                .handshake_o (handshakes[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (VALID_IN) begin
                    load = 1'b1;
                    // An empty mask completes immediately without entering SEND.
                    if (LANE_MASK_IN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if ((valids & ~handshakes) == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            values_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                values_q <= VALUES_IN;
            end
        end
    end

    assign READY_OUT  = (state_q == IDLE);
    assign VALUES_OUT = values_q;
    assign VALIDS_OUT = valids;
    assign DONE_OUT   = done_q;

endmodule : shim_fanout
